pipe_stall_ctrl: RTL and testbench

- Hazard and multi-cycle scheduler for the 5-stage pipeline.
- Decides each cycle whether the D-stage instruction may advance, using Tuse (D) against Tnew (E, M).
- Owns the mult/div busy sequencer that holds the E/M datapath's MD unit for a fixed latency.
- Drives the PC and F/D enables and the D/E bubble flush, and keeps a stall-cycle performance counter.

---
 rtl/pipe_stall_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall scheduler for the 5-stage pipeline: Tuse/Tnew data-hazard detection,
// mult/div busy sequencing, PC/F-D enables, D/E bubble insertion and a stall counter.
module pipe_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs_D,
    input  logic [1:0]  tuse_rt_D,
    input  logic        md_use_D,
    input  logic [4:0]  wreg_E,
    input  logic [1:0]  tnew_E,
    input  logic [4:0]  wreg_M,
    input  logic [1:0]  tnew_M,
    input  logic        md_start_E,
    input  logic        md_is_div_E,
    output logic        pc_en,
    output logic        fd_en,
    output logic        de_flush,
    output logic        stall,
    output logic        md_busy,
    output logic [31:0] stall_count
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Index 0 = rs / E stage, index 1 = rt / M stage.
    logic [4:0] src_reg  [2];
    logic [1:0] src_tuse [2];
    logic [4:0] dst_reg  [2];
    logic [1:0] dst_tnew [2];

    assign src_reg[0]  = rs_D;
    assign src_reg[1]  = rt_D;
    assign src_tuse[0] = tuse_rs_D;
    assign src_tuse[1] = tuse_rt_D;
    assign dst_reg[0]  = wreg_E;
    assign dst_reg[1]  = wreg_M;
    assign dst_tnew[0] = tnew_E;
    assign dst_tnew[1] = tnew_M;

    logic [1:0] src_stall;
    logic       stall_md;

    // A source stalls when any in-flight producer of the same register delivers too late.
    // tuse = 3 can never be exceeded by tnew (max 2), so unread operands never stall.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic [1:0] hit;
            for (genvar gj = 0; gj < 2; gj++) begin : g_dst
                assign hit[gj] = (src_reg[gi] == dst_reg[gj]) &&
                                 (dst_tnew[gj] > src_tuse[gi]);
            end
            assign src_stall[gi] = (src_reg[gi] != 5'd0) && (|hit);
        end
    endgenerate

    assign stall_md = md_use_D && (md_start_E || md_busy);
    assign stall    = (|src_stall) || stall_md;
    assign pc_en    = ~stall;
    assign fd_en    = ~stall;
    assign de_flush = stall;

    md_state_t        state_reg;
    logic [CNT_W-1:0] busy_cnt_reg;
    logic             md_busy_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            busy_cnt_reg <= '0;
            md_busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (md_start_E) begin
                        state_reg    <= BUSY;
                        md_busy_reg  <= 1'b1;
                        busy_cnt_reg <= md_is_div_E ? DIV_LOAD : MULT_LOAD;
                    end
                end
                BUSY: begin
                    // New starts are ignored while the unit is occupied.
                    if (busy_cnt_reg == CNT_ONE) begin
                        state_reg    <= IDLE;
                        md_busy_reg  <= 1'b0;
                        busy_cnt_reg <= '0;
                    end else begin
                        busy_cnt_reg <= busy_cnt_reg - CNT_ONE;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    md_busy_reg  <= 1'b0;
                    busy_cnt_reg <= '0;
                end
            endcase
        end
    end

    assign md_busy = md_busy_reg;

    logic [31:0] stall_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_reg <= '0;
        end else if (stall && (stall_count_reg != 32'hFFFF_FFFF)) begin
            stall_count_reg <= stall_count_reg + 32'd1;
        end
    end

    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed vectors push expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_D, rt_D, wreg_E, wreg_M;
    logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
    logic        md_use_D, md_start_E, md_is_div_E;
    logic        pc_en, fd_en, de_flush, stall, md_busy;
    logic [31:0] stall_count;

    int checks = 0;
    int errors = 0;

    string       q_name  [$];
    logic        q_stall [$];
    logic        q_busy  [$];
    logic [31:0] q_cnt   [$];

    logic [31:0] exp_cnt;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10),
        .CNT_W      (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rs_D       (rs_D),
        .rt_D       (rt_D),
        .tuse_rs_D  (tuse_rs_D),
        .tuse_rt_D  (tuse_rt_D),
        .md_use_D   (md_use_D),
        .wreg_E     (wreg_E),
        .tnew_E     (tnew_E),
        .wreg_M     (wreg_M),
        .tnew_M     (tnew_M),
        .md_start_E (md_start_E),
        .md_is_div_E(md_is_div_E),
        .pc_en      (pc_en),
        .fd_en      (fd_en),
        .de_flush   (de_flush),
        .stall      (stall),
        .md_busy    (md_busy),
        .stall_count(stall_count)
    );

    task automatic chk1(input string nm, input string fld, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %0b expected %0b", nm, fld, act, exp);
        end
    endtask

    // Monitor: every cycle with an outstanding expectation is one transaction.
    always @(negedge clk) begin
        if (q_name.size() > 0) begin
            string       nm;
            logic        es, eb;
            logic [31:0] ec;
            nm = q_name.pop_front();
            es = q_stall.pop_front();
            eb = q_busy.pop_front();
            ec = q_cnt.pop_front();
            chk1(nm, "stall", stall, es);
            chk1(nm, "pc_en", pc_en, ~es);
            chk1(nm, "fd_en", fd_en, ~es);
            chk1(nm, "de_flush", de_flush, es);
            chk1(nm, "md_busy", md_busy, eb);
            checks++;
            if (stall_count !== ec) begin
                errors++;
                $display("FAIL %s.stall_count got %h expected %h", nm, stall_count, ec);
            end
            $display("txn %-14s stall=%0b busy=%0b count=%h", nm, stall, md_busy, stall_count);
        end
    end

    task automatic idle_inputs();
        rs_D = 5'd0;  rt_D = 5'd0;
        tuse_rs_D = 2'd3; tuse_rt_D = 2'd3;
        md_use_D = 1'b0;
        wreg_E = 5'd0; tnew_E = 2'd0;
        wreg_M = 5'd0; tnew_M = 2'd0;
        md_start_E = 1'b0; md_is_div_E = 1'b0;
    endtask

    // Issue one cycle: push expectation for this cycle, then advance the model over the edge.
    task automatic step(input string nm, input logic es, input logic eb);
        q_name.push_back(nm);
        q_stall.push_back(es);
        q_busy.push_back(eb);
        q_cnt.push_back(exp_cnt);
        @(posedge clk);
        if (reset) exp_cnt = 32'd0;
        else if (es && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        exp_cnt = 32'd0;
        @(posedge clk); #1;
        step("reset", 1'b0, 1'b0);
        reset = 1'b0;

        // Load-use: E result 2 cycles away, needed in 1.
        rs_D = 5'd8; tuse_rs_D = 2'd1; wreg_E = 5'd8; tnew_E = 2'd2;
        step("load_use", 1'b1, 1'b0);
        // Forwardable from M.
        wreg_E = 5'd0; tnew_E = 2'd0; wreg_M = 5'd8; tnew_M = 2'd1;
        step("fwd_M", 1'b0, 1'b0);
        // Register 0 never stalls.
        idle_inputs(); tuse_rs_D = 2'd0; wreg_E = 5'd0; tnew_E = 2'd2;
        step("reg0", 1'b0, 1'b0);
        // rt hazard against M.
        idle_inputs(); rt_D = 5'd5; tuse_rt_D = 2'd0; wreg_M = 5'd5; tnew_M = 2'd1;
        step("rt_M", 1'b1, 1'b0);
        // Unread operand never stalls.
        idle_inputs(); rs_D = 5'd7; tuse_rs_D = 2'd3; wreg_E = 5'd7; tnew_E = 2'd2;
        step("tuse3", 1'b0, 1'b0);
        // Both stages match: E late alone, then M late alone.
        idle_inputs(); rs_D = 5'd9; tuse_rs_D = 2'd0;
        wreg_E = 5'd9; tnew_E = 2'd1; wreg_M = 5'd9; tnew_M = 2'd0;
        step("both_E_late", 1'b1, 1'b0);
        tnew_E = 2'd0; tnew_M = 2'd1;
        step("both_M_late", 1'b1, 1'b0);
        tnew_M = 2'd0;
        step("both_ready", 1'b0, 1'b0);

        // Mult: 5 busy cycles, md_use_D stalls through start and busy.
        idle_inputs(); md_use_D = 1'b1; md_start_E = 1'b1;
        step("mul_start", 1'b1, 1'b0);
        md_start_E = 1'b0;
        for (int k = 1; k <= 5; k++) step($sformatf("mul_busy%0d", k), 1'b1, 1'b1);
        step("mul_done", 1'b0, 1'b0);

        // Div with ignored restart at busy cycle 3.
        idle_inputs(); md_start_E = 1'b1; md_is_div_E = 1'b1;
        step("div_start", 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            md_start_E = (k == 3);
            md_is_div_E = 1'b0;
            step($sformatf("div_busy%0d", k), 1'b0, 1'b1);
        end
        md_start_E = 1'b0;
        step("div_done", 1'b0, 1'b0);

        // Reset at busy cycle 4 of a div; stall stays combinational during reset.
        idle_inputs(); md_start_E = 1'b1; md_is_div_E = 1'b1;
        step("rdiv_start", 1'b0, 1'b0);
        md_start_E = 1'b0;
        for (int k = 1; k <= 3; k++) step($sformatf("rdiv_busy%0d", k), 1'b0, 1'b1);
        reset = 1'b1; md_use_D = 1'b1;
        step("rdiv_reset", 1'b1, 1'b1);
        reset = 1'b0; md_use_D = 1'b0; md_start_E = 1'b1; md_is_div_E = 1'b0;
        step("rmul_start", 1'b0, 1'b0);
        md_start_E = 1'b0;
        for (int k = 1; k <= 5; k++) step($sformatf("rmul_busy%0d", k), 1'b0, 1'b1);
        step("rmul_done", 1'b0, 1'b0);

        // Saturation: preload the counter just below the top.
        idle_inputs(); rs_D = 5'd8; tuse_rs_D = 2'd1; wreg_E = 5'd8; tnew_E = 2'd2;
        force dut.stall_count_reg = 32'hFFFF_FFFE;
        #1;
        release dut.stall_count_reg;
        exp_cnt = 32'hFFFF_FFFE;
        step("sat1", 1'b1, 1'b0);
        step("sat2", 1'b1, 1'b0);
        step("sat3", 1'b1, 1'b0);
        idle_inputs();
        step("sat_hold", 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        checks++;
        if (q_name.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", q_name.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
